// File: rtl/rlc_game_system_cpu_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : rlc_game_system_cpu_oci_dct_packer
// Purpose  : Packs 2-bit direct-branch trace atoms into 15-atom packets and
//            hands closed packets to a one-entry valid/ready output register.
//            Packets that find the register occupied are dropped, never
//            stalled, and the loss is reported through overflow/pkt_lost.
// Revision : 1.0 - initial release
// ============================================================================
module rlc_game_system_cpu_oci_dct_packer #(
   parameter int ATOM_W = 2,
   parameter int DEPTH  = 15
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          atom_valid,
   input  logic [ATOM_W-1:0]             atom,
   input  logic                          flush,
   output logic [ATOM_W*DEPTH-1:0]       dct_buffer,
   output logic [$clog2(DEPTH+1)-1:0]    dct_count,
   output logic                          pkt_valid,
   output logic [ATOM_W*DEPTH-1:0]       pkt_data,
   output logic [$clog2(DEPTH+1)-1:0]    pkt_count,
   output logic                          pkt_lost,
   input  logic                          pkt_ready,
   output logic                          overflow,
   input  logic                          overflow_clr
);

   localparam int c_BUF_W = ATOM_W * DEPTH;
   localparam int c_CNT_W = $clog2(DEPTH + 1);

   logic [c_BUF_W-1:0] r_buf;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_pkt_valid;
   logic [c_BUF_W-1:0] r_pkt_data;
   logic [c_CNT_W-1:0] r_pkt_count;
   logic               r_pkt_lost;
   logic               r_lost;
   logic               r_overflow;

   logic [c_BUF_W-1:0] w_ins_buf;
   logic [c_CNT_W-1:0] w_ins_cnt;
   logic               w_close;
   logic               w_out_free;
   logic               w_drop;

   // Post-insert view of the accumulator and the packet close / drop decision.
   // Bits above the count are always zero, so OR-ing the shifted atom in is
   // equivalent to writing the slot.
   always_comb begin
      w_ins_buf = r_buf;
      w_ins_cnt = r_cnt;
      if (atom_valid) begin
         w_ins_buf = r_buf | (c_BUF_W'(atom) << (ATOM_W * int'(r_cnt)));
         w_ins_cnt = r_cnt + c_CNT_W'(1);
      end
      w_close    = (atom_valid && (w_ins_cnt == c_CNT_W'(DEPTH))) ||
                   (flush && (w_ins_cnt != '0));
      w_out_free = !r_pkt_valid || pkt_ready;
      w_drop     = w_close && !w_out_free;
   end

   // Accumulator: insert atoms, clear on every close (delivered or dropped).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_buf <= '0;
         r_cnt <= '0;
      end else if (w_close) begin
         r_buf <= '0;
         r_cnt <= '0;
      end else begin
         r_buf <= w_ins_buf;
         r_cnt <= w_ins_cnt;
      end
   end

   // Output register: load when free, hold while stalled, remember drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pkt_valid <= 1'b0;
         r_pkt_data  <= '0;
         r_pkt_count <= '0;
         r_pkt_lost  <= 1'b0;
         r_lost      <= 1'b0;
      end else if (w_out_free) begin
         if (w_close) begin
            r_pkt_valid <= 1'b1;
            r_pkt_data  <= w_ins_buf;
            r_pkt_count <= w_ins_cnt;
            r_pkt_lost  <= r_lost;
            r_lost      <= 1'b0;
         end else begin
            r_pkt_valid <= 1'b0;
         end
      end else if (w_drop) begin
         r_lost <= 1'b1;
      end
   end

   // Sticky overflow flag; a drop in the same cycle beats the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (overflow_clr) begin
         r_overflow <= 1'b0;
      end
   end

   assign dct_buffer = r_buf;
   assign dct_count  = r_cnt;
   assign pkt_valid  = r_pkt_valid;
   assign pkt_data   = r_pkt_data;
   assign pkt_count  = r_pkt_count;
   assign pkt_lost   = r_pkt_lost;
   assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rlc_game_system_cpu_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rlc_game_system_cpu_oci_dct_packer
// Purpose  : Self-checking bench for the DCT atom packer: directed scenarios
//            plus randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rlc_game_system_cpu_oci_dct_packer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        atom_valid = 1'b0;
   logic [1:0]  atom = 2'b00;
   logic        flush = 1'b0;
   logic        pkt_ready = 1'b0;
   logic        overflow_clr = 1'b0;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        pkt_valid;
   logic [29:0] pkt_data;
   logic [3:0]  pkt_count;
   logic        pkt_lost;
   logic        overflow;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state: the accumulator is a plain queue of atoms.
   logic [1:0]  m_acc[$];
   bit          m_pv;
   logic [29:0] m_pd;
   logic [3:0]  m_pc;
   bit          m_pl;
   bit          m_lost;
   bit          m_ovf;

   rlc_game_system_cpu_oci_dct_packer dut (
      .clk          (clk),
      .reset        (reset),
      .atom_valid   (atom_valid),
      .atom         (atom),
      .flush        (flush),
      .dct_buffer   (dct_buffer),
      .dct_count    (dct_count),
      .pkt_valid    (pkt_valid),
      .pkt_data     (pkt_data),
      .pkt_count    (pkt_count),
      .pkt_lost     (pkt_lost),
      .pkt_ready    (pkt_ready),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   always #5 clk = ~clk;

   function automatic logic [29:0] pack_acc();
      logic [29:0] v = '0;
      for (int i = 0; i < m_acc.size(); i++)
         v = v + (30'(m_acc[i]) * (30'd1 << (2 * i)));
      return v;
   endfunction

   task automatic model_reset();
      m_acc.delete();
      m_pv = 0; m_pd = '0; m_pc = '0; m_pl = 0; m_lost = 0; m_ovf = 0;
   endtask

   task automatic model_step(input bit av, input logic [1:0] a, input bit fl,
                             input bit rdy, input bit clr);
      bit          free;
      bit          close;
      logic [29:0] d;
      int          n;
      free = !m_pv || rdy;
      if (av) m_acc.push_back(a);
      n     = m_acc.size();
      close = (n == 15) || (fl && n > 0);
      d     = pack_acc();
      if (close) m_acc.delete();
      if (clr) m_ovf = 0;
      if (free) begin
         if (close) begin
            m_pv = 1; m_pd = d; m_pc = 4'(n); m_pl = m_lost; m_lost = 0;
         end else begin
            m_pv = 0;
         end
      end else if (close) begin
         m_ovf = 1; m_lost = 1;
      end
   endtask

   // One clock: drive on the falling edge, let the DUT take the rising edge,
   // then settle 1 time unit before the caller samples.
   task automatic tick(input bit av, input logic [1:0] a, input bit fl,
                       input bit rdy, input bit clr);
      @(negedge clk);
      atom_valid = av; atom = a; flush = fl; pkt_ready = rdy; overflow_clr = clr;
      @(posedge clk);
      model_step(av, a, fl, rdy, clr);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      atom_valid = 0; atom = 0; flush = 0; pkt_ready = 0; overflow_clr = 0;
      reset = 1;
      model_reset();
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      vectors++; if (dct_buffer !== 30'd0) begin miscompares++; $display("FAIL reset_buffer got %h want 0", dct_buffer); end
      vectors++; if (dct_count !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", dct_count); end
      vectors++; if (pkt_valid !== 1'b0) begin miscompares++; $display("FAIL reset_pkt_valid got %b want 0", pkt_valid); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", overflow); end
   endtask

   task automatic test_full_packet();
      apply_reset();
      for (int i = 0; i < 15; i++) begin
         tick(1, 2'b01, 0, 1, 0);
         vectors++;
         if (dct_count !== 4'((i + 1) % 15)) begin
            miscompares++;
            $display("FAIL full_count[%0d] got %0d want %0d", i, dct_count, (i + 1) % 15);
         end
      end
      vectors++; if (pkt_valid !== 1'b1) begin miscompares++; $display("FAIL full_pkt_valid got %b want 1", pkt_valid); end
      vectors++; if (pkt_data !== 30'h15555555) begin miscompares++; $display("FAIL full_pkt_data got %h want 15555555", pkt_data); end
      vectors++; if (pkt_count !== 4'd15) begin miscompares++; $display("FAIL full_pkt_count got %0d want 15", pkt_count); end
      vectors++; if (pkt_lost !== 1'b0) begin miscompares++; $display("FAIL full_pkt_lost got %b want 0", pkt_lost); end
      vectors++; if (dct_buffer !== 30'd0) begin miscompares++; $display("FAIL full_buffer_clear got %h want 0", dct_buffer); end
      tick(0, 2'b00, 0, 1, 0);
      vectors++; if (pkt_valid !== 1'b0) begin miscompares++; $display("FAIL full_handshake got %b want 0", pkt_valid); end
   endtask

   task automatic test_flush();
      apply_reset();
      tick(1, 2'b10, 0, 1, 0);
      tick(1, 2'b11, 0, 1, 0);
      tick(1, 2'b01, 0, 1, 0);
      vectors++; if (dct_buffer !== 30'h1E) begin miscompares++; $display("FAIL flush_live_buffer got %h want 1e", dct_buffer); end
      tick(0, 2'b00, 1, 1, 0);
      vectors++; if (pkt_valid !== 1'b1) begin miscompares++; $display("FAIL flush_pkt_valid got %b want 1", pkt_valid); end
      vectors++; if (pkt_data !== 30'h1E) begin miscompares++; $display("FAIL flush_pkt_data got %h want 1e", pkt_data); end
      vectors++; if (pkt_count !== 4'd3) begin miscompares++; $display("FAIL flush_pkt_count got %0d want 3", pkt_count); end
      vectors++; if (dct_buffer !== 30'd0) begin miscompares++; $display("FAIL flush_buffer_clear got %h want 0", dct_buffer); end
      // Empty flush: the handshake retires the packet and nothing replaces it.
      tick(0, 2'b00, 1, 1, 0);
      vectors++; if (pkt_valid !== 1'b0) begin miscompares++; $display("FAIL empty_flush_valid got %b want 0", pkt_valid); end
      tick(0, 2'b00, 1, 1, 0);
      vectors++; if (pkt_valid !== 1'b0) begin miscompares++; $display("FAIL empty_flush_valid2 got %b want 0", pkt_valid); end
   endtask

   task automatic test_atom_with_flush();
      apply_reset();
      for (int i = 0; i < 4; i++) tick(1, 2'b00, 0, 1, 0);
      vectors++; if (dct_count !== 4'd4) begin miscompares++; $display("FAIL atomflush_pre_count got %0d want 4", dct_count); end
      tick(1, 2'b11, 1, 1, 0);
      vectors++; if (pkt_count !== 4'd5) begin miscompares++; $display("FAIL atomflush_count got %0d want 5", pkt_count); end
      vectors++; if (pkt_data !== 30'h300) begin miscompares++; $display("FAIL atomflush_data got %h want 300", pkt_data); end
      // 15th atom together with flush yields exactly one packet of 15.
      for (int i = 0; i < 14; i++) tick(1, 2'b10, 0, 1, 0);
      tick(1, 2'b10, 1, 1, 0);
      vectors++; if (pkt_count !== 4'd15) begin miscompares++; $display("FAIL full_flush_count got %0d want 15", pkt_count); end
      vectors++; if (pkt_data !== 30'h2AAAAAAA) begin miscompares++; $display("FAIL full_flush_data got %h want 2aaaaaaa", pkt_data); end
      tick(0, 2'b00, 0, 1, 0);
      vectors++; if (pkt_valid !== 1'b0) begin miscompares++; $display("FAIL full_flush_single got %b want 0", pkt_valid); end
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int i = 0; i < 15; i++) tick(1, 2'b01, 0, 0, 0);
      vectors++; if (pkt_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_first_valid got %b want 1", pkt_valid); end
      for (int i = 0; i < 15; i++) tick(1, 2'b10, 0, 0, 0);
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set got %b want 1", overflow); end
      vectors++; if (pkt_data !== 30'h15555555) begin miscompares++; $display("FAIL ovf_held_data got %h want 15555555", pkt_data); end
      vectors++; if (pkt_lost !== 1'b0) begin miscompares++; $display("FAIL ovf_held_lost got %b want 0", pkt_lost); end
      vectors++; if (dct_count !== 4'd0) begin miscompares++; $display("FAIL ovf_acc_clear got %0d want 0", dct_count); end
      tick(0, 2'b00, 0, 1, 0);
      vectors++; if (pkt_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_delivered got %b want 0", pkt_valid); end
      tick(1, 2'b11, 1, 1, 0);
      vectors++; if (pkt_lost !== 1'b1) begin miscompares++; $display("FAIL ovf_next_lost got %b want 1", pkt_lost); end
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b want 1", overflow); end
      tick(0, 2'b00, 0, 1, 1);
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clr got %b want 0", overflow); end
      tick(1, 2'b01, 1, 1, 0);
      vectors++; if (pkt_lost !== 1'b0) begin miscompares++; $display("FAIL ovf_lost_cleared got %b want 0", pkt_lost); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      tick(1, 2'b01, 1, 0, 0);
      for (int i = 0; i < 7; i++) tick(1, 2'b11, 0, 0, 0);
      vectors++; if (dct_count !== 4'd7 || pkt_valid !== 1'b1) begin miscompares++; $display("FAIL areset_setup got cnt=%0d v=%b want cnt=7 v=1", dct_count, pkt_valid); end
      @(posedge clk);
      #3 reset = 1;
      #1;
      vectors++;
      if (dct_buffer !== 30'd0 || dct_count !== 4'd0 || pkt_valid !== 1'b0 || pkt_data !== 30'd0 ||
          pkt_count !== 4'd0 || pkt_lost !== 1'b0 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL areset_immediate got buf=%h cnt=%0d v=%b d=%h c=%0d l=%b o=%b want all 0",
                  dct_buffer, dct_count, pkt_valid, pkt_data, pkt_count, pkt_lost, overflow);
      end
      model_reset();
      @(negedge clk);
      atom_valid = 0; flush = 0; pkt_ready = 0; overflow_clr = 0;
      reset = 0;
   endtask

   task automatic test_random();
      bit          av, fl, rdy, clr;
      logic [1:0]  a;
      logic [29:0] mbuf;
      apply_reset();
      for (int c = 0; c < 600; c++) begin
         av  = ($urandom_range(0, 3) != 0);
         a   = 2'($urandom_range(0, 3));
         fl  = ($urandom_range(0, 7) == 0);
         rdy = ($urandom_range(0, 2) != 0);
         clr = ($urandom_range(0, 15) == 0);
         tick(av, a, fl, rdy, clr);
         mbuf = pack_acc();
         vectors++; if (dct_buffer !== mbuf) begin miscompares++; $display("FAIL rnd_buffer[%0d] got %h want %h", c, dct_buffer, mbuf); end
         vectors++; if (dct_count !== 4'(m_acc.size())) begin miscompares++; $display("FAIL rnd_count[%0d] got %0d want %0d", c, dct_count, m_acc.size()); end
         vectors++; if (pkt_valid !== m_pv) begin miscompares++; $display("FAIL rnd_pkt_valid[%0d] got %b want %b", c, pkt_valid, m_pv); end
         vectors++; if (overflow !== m_ovf) begin miscompares++; $display("FAIL rnd_overflow[%0d] got %b want %b", c, overflow, m_ovf); end
         if (m_pv) begin
            vectors++;
            if (pkt_data !== m_pd || pkt_count !== m_pc || pkt_lost !== m_pl) begin
               miscompares++;
               $display("FAIL rnd_pkt[%0d] got d=%h c=%0d l=%b want d=%h c=%0d l=%b",
                        c, pkt_data, pkt_count, pkt_lost, m_pd, m_pc, m_pl);
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_full_packet();
      test_flush();
      test_atom_with_flush();
      test_overflow();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
